// File: rtl/mem_responder_pkg.sv
// Shared CPU memory-side types: responder state, initiator port id, request record.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_resp_state_t;

  typedef enum logic {
    PORT_I   = 1'b0,
    PORT_LSQ = 1'b1
  } mem_port_t;

  localparam int MEM_W = 32;

  typedef struct packed {
    logic               read;
    logic               write;
    logic [MEM_W/8-1:0] byte_enable;
    logic [MEM_W-1:0]   address;
    logic [MEM_W-1:0]   wdata;
  } mem_req_t;

  function automatic mem_port_t other_port(mem_port_t p);
    return (p == PORT_I) ? PORT_LSQ : PORT_I;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Simple memory request/response bus: the initiator drives the request,
// the responder returns a one-cycle resp with read data.
interface mem_responder_if #(
  parameter int width = 32
);
  logic               read;
  logic               write;
  logic [width/8-1:0] byte_enable;
  logic [width-1:0]   address;
  logic [width-1:0]   wdata;
  logic               resp;
  logic [width-1:0]   rdata;

  modport master (
    output read, write, byte_enable, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, byte_enable, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/mem_responder_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// port that was not granted last.
module rr_arbiter2
  import rv32i_types::*;
(
  input  logic      req_i,
  input  logic      req_lsq,
  input  mem_port_t last_grant,
  output mem_port_t grant,
  output logic      valid
);

  // Pick the winner from the two request bits and the grant history
  always_comb begin
    valid = req_i | req_lsq;
    grant = PORT_I;
    if (req_i && req_lsq) begin
      grant = other_port(last_grant);
    end else if (req_lsq) begin
      grant = PORT_LSQ;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: serialises fetch and LSQ requests onto one pmem port,
// one transaction at a time, with a watchdog that aborts a stalled pmem.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration happens here only
//   BUSY  | pmem request driven from latched copy; watchdog running
//   RESP  | one-cycle resp to the granted port; grant history updated
module mem_responder
  import rv32i_types::*;
#(
  parameter int width   = 32,
  parameter int timeout = 255
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  i_mem,
  mem_responder_if.slave  lsq_mem,
  mem_responder_if.master pmem,
  output logic            err
);

  localparam int         BE_W    = width / 8;
  // Watchdog value in the last BUSY cycle allowed before the abort.
  localparam logic [7:0] WD_LAST = 8'(timeout - 1);

  mem_resp_state_t  state;
  mem_port_t        last_grant;
  mem_port_t        cur_port;
  mem_port_t        grant;
  logic             grant_valid;
  logic [7:0]       wd_cnt;

  logic             sel_write;
  logic [BE_W-1:0]  sel_be;
  logic [width-1:0] sel_address;
  logic [width-1:0] sel_wdata;
  logic [width-1:0] cap_data;

  rr_arbiter2 u_arb (
    .req_i      (i_mem.read | i_mem.write),
    .req_lsq    (lsq_mem.read | lsq_mem.write),
    .last_grant (last_grant),
    .grant      (grant),
    .valid      (grant_valid)
  );

  // Route the winning port's request fields to the latch inputs
  always_comb begin
    if (grant == PORT_I) begin
      sel_write   = i_mem.write;
      sel_be      = i_mem.byte_enable;
      sel_address = i_mem.address;
      sel_wdata   = i_mem.wdata;
    end else begin
      sel_write   = lsq_mem.write;
      sel_be      = lsq_mem.byte_enable;
      sel_address = lsq_mem.address;
      sel_wdata   = lsq_mem.wdata;
    end
  end

  // Writes return zero data regardless of what pmem puts on rdata
  assign cap_data = pmem.write ? '0 : pmem.rdata;

  // Transaction FSM; all pmem and resp outputs are registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      last_grant        <= PORT_LSQ;
      cur_port          <= PORT_I;
      wd_cnt            <= '0;
      err               <= 1'b0;
      pmem.read         <= 1'b0;
      pmem.write        <= 1'b0;
      pmem.byte_enable  <= '0;
      pmem.address      <= '0;
      pmem.wdata        <= '0;
      i_mem.resp        <= 1'b0;
      i_mem.rdata       <= '0;
      lsq_mem.resp      <= 1'b0;
      lsq_mem.rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state            <= BUSY;
            cur_port         <= grant;
            wd_cnt           <= '0;
            pmem.write       <= sel_write;
            pmem.read        <= ~sel_write;
            pmem.byte_enable <= sel_be;
            pmem.address     <= sel_address;
            pmem.wdata       <= sel_wdata;
          end
        end
        BUSY: begin
          // A response in the watchdog's final cycle still wins over the abort
          if (pmem.resp || (wd_cnt == WD_LAST)) begin
            state      <= RESP;
            pmem.read  <= 1'b0;
            pmem.write <= 1'b0;
            if (!pmem.resp) begin
              err <= 1'b1;
            end
            if (cur_port == PORT_I) begin
              i_mem.resp  <= 1'b1;
              i_mem.rdata <= pmem.resp ? cap_data : '0;
            end else begin
              lsq_mem.resp  <= 1'b1;
              lsq_mem.rdata <= pmem.resp ? cap_data : '0;
            end
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        RESP: begin
          state        <= IDLE;
          last_grant   <= cur_port;
          i_mem.resp   <= 1'b0;
          lsq_mem.resp <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a transaction-level scoreboard.
module tb_mem_responder;
  import rv32i_types::*;

  localparam int W   = 32;
  localparam int TMO = 4;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_s;

  typedef struct {
    mem_port_t   port;
    logic        write;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          busy;
    logic        tmo;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  mem_responder_if #(.width(W)) i_bus ();
  mem_responder_if #(.width(W)) l_bus ();
  mem_responder_if #(.width(W)) p_bus ();

  mem_responder #(.width(W), .timeout(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_mem   (i_bus),
    .lsq_mem (l_bus),
    .pmem    (p_bus),
    .err     (err)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  mem_port_t   resp_log[$];
  logic [31:0] m_rdata_i = '0;
  logic [31:0] m_rdata_l = '0;
  logic        m_err = 1'b0;
  mem_port_t   m_last = PORT_LSQ;
  int          pmem_lat = 1;
  logic [31:0] pmem_base = '0;
  logic        inject_resp = 1'b0;
  logic        run_chk = 1'b0;
  int          busy_cnt = 0;
  int          resp_cnt = 0;
  int          pcnt = 0;
  exp_t        cur_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // What the responder must do with a request, given the pmem behaviour set up for it
  function automatic exp_t predict(input mem_port_t p, input req_s r);
    exp_t e;
    e.port  = p;
    e.write = r.wr;
    e.be    = r.be;
    e.addr  = r.addr;
    e.wdata = r.wdata;
    if (pmem_lat >= 1 && pmem_lat <= TMO) begin
      e.busy = pmem_lat;
      e.tmo  = 1'b0;
    end else begin
      e.busy = TMO;
      e.tmo  = 1'b1;
    end
    e.rdata = (e.tmo || r.wr) ? 32'h0 : (pmem_base ^ r.addr);
    return e;
  endfunction

  // Downstream memory: answers after pmem_lat BUSY cycles (never if 0)
  always @(negedge clk) begin
    if (!rst || !(p_bus.read || p_bus.write)) begin
      pcnt        = 0;
      p_bus.resp  = rst ? inject_resp : 1'b0;
      p_bus.rdata = 32'h5A5A_5A5A;
    end else begin
      pcnt++;
      if (pcnt == pmem_lat) begin
        p_bus.resp  = 1'b1;
        p_bus.rdata = pmem_base ^ p_bus.address;
      end else begin
        p_bus.resp  = 1'b0;
        p_bus.rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      busy_cnt = 0;
    end else if (run_chk) begin
      if (p_bus.read || p_bus.write) begin
        if (exp_q.size() == 0) begin
          check("pmem_unexpected", 128'(exp_q.size()), 128'd1);
        end else begin
          check("pmem_req",
                {p_bus.read, p_bus.write, p_bus.byte_enable, p_bus.address, p_bus.wdata},
                {~exp_q[0].write, exp_q[0].write, exp_q[0].be, exp_q[0].addr, exp_q[0].wdata});
        end
        busy_cnt++;
      end
      check("resp_exclusive", 128'(i_bus.resp & l_bus.resp), 128'd0);
      if (i_bus.resp || l_bus.resp) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_resp", 128'(exp_q.size()), 128'd1);
        end else begin
          cur_e = exp_q.pop_front();
          check("resp_port", 128'(l_bus.resp), 128'(cur_e.port == PORT_LSQ));
          check("busy_len", 128'(busy_cnt), 128'(cur_e.busy));
          if (cur_e.port == PORT_I) m_rdata_i = cur_e.rdata;
          else                      m_rdata_l = cur_e.rdata;
          if (cur_e.tmo) m_err = 1'b1;
          resp_log.push_back(l_bus.resp ? PORT_LSQ : PORT_I);
        end
        busy_cnt = 0;
      end
      check("i_rdata", 128'(i_bus.rdata), 128'(m_rdata_i));
      check("lsq_rdata", 128'(l_bus.rdata), 128'(m_rdata_l));
      check("err", 128'(err), 128'(m_err));
    end
  end

  task automatic drive_i(input req_s r);
    i_bus.read = r.rd; i_bus.write = r.wr; i_bus.byte_enable = r.be;
    i_bus.address = r.addr; i_bus.wdata = r.wdata;
  endtask

  task automatic drive_l(input req_s r);
    l_bus.read = r.rd; l_bus.write = r.wr; l_bus.byte_enable = r.be;
    l_bus.address = r.addr; l_bus.wdata = r.wdata;
  endtask

  // Issue a request on one or both ports, act as the initiator until every resp arrives
  task automatic run_req(input logic do_i, input req_s ri, input logic do_l, input req_s rl,
                         input logic toggle, input int budget);
    exp_t      e1;
    exp_t      e2;
    mem_port_t first;
    int        need;
    int        got;
    int        n;
    int        first_n;
    logic      done_i;
    logic      done_l;
    req_s      idle_r;
    idle_r = '{default: '0};
    if (do_i && do_l) begin
      first = (m_last == PORT_LSQ) ? PORT_I : PORT_LSQ;
      e1 = predict(first, (first == PORT_I) ? ri : rl);
      e2 = predict((first == PORT_I) ? PORT_LSQ : PORT_I, (first == PORT_I) ? rl : ri);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      m_last = e2.port;
    end else begin
      e1 = predict(do_i ? PORT_I : PORT_LSQ, do_i ? ri : rl);
      exp_q.push_back(e1);
      m_last = e1.port;
    end
    if (do_i) drive_i(ri);
    if (do_l) drive_l(rl);
    need = int'(do_i) + int'(do_l);
    got = 0; n = 0; first_n = -1;
    done_i = ~do_i; done_l = ~do_l;
    while (got < need && n < budget) begin
      @(negedge clk);
      n++;
      if (i_bus.resp) begin got++; done_i = 1'b1; if (first_n < 0) first_n = n; end
      if (l_bus.resp) begin got++; done_l = 1'b1; if (first_n < 0) first_n = n; end
      @(posedge clk);
      #1;
      if (done_i) drive_i(idle_r);
      else if (toggle) begin
        i_bus.address = $urandom(); i_bus.wdata = $urandom(); i_bus.byte_enable = 4'($urandom());
      end
      if (done_l) drive_l(idle_r);
      else if (toggle) begin
        l_bus.address = $urandom(); l_bus.wdata = $urandom(); l_bus.byte_enable = 4'($urandom());
      end
    end
    check("resp_count", 128'(got), 128'(need));
    if (need == 1) check("req_to_resp_latency", 128'(first_n - 1), 128'(e1.busy + 1));
    if (got < need) begin
      exp_q.delete();
      drive_i(idle_r);
      drive_l(idle_r);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    req_s idle_r;
    req_s ri;
    req_s rl;
    int   rc;
    idle_r = '{default: '0};
    drive_i(idle_r);
    drive_l(idle_r);
    rst = 1'b1;
    #1 rst = 1'b0;
    #11;
    check("rst_pmem_ctl", {p_bus.read, p_bus.write, i_bus.resp, l_bus.resp, err}, 128'd0);
    check("rst_pmem_data", {p_bus.byte_enable, p_bus.address, p_bus.wdata}, 128'd0);
    check("rst_rdata", {i_bus.rdata, l_bus.rdata}, 128'd0);
    #10 rst = 1'b1;
    @(posedge clk);
    #1;
    run_chk = 1'b1;

    // Tie straight after reset: fetch first, then LSQ
    pmem_lat = 2; pmem_base = 32'h1111_0000;
    ri = '{1'b1, 1'b0, 4'hF, 32'h200, 32'h0};
    rl = '{1'b1, 1'b0, 4'hF, 32'h300, 32'h0};
    resp_log.delete();
    run_req(1'b1, ri, 1'b1, rl, 1'b0, 30);
    check("tie1_count", 128'(resp_log.size()), 128'd2);
    if (resp_log.size() == 2) check("tie1_order", {resp_log[0], resp_log[1]}, 128'b01);
    check("tie1_lsq_rdata_lit", 128'(l_bus.rdata), 128'h1111_0300);

    // Second tie: LSQ was granted last, so fetch leads again
    resp_log.delete();
    run_req(1'b1, ri, 1'b1, rl, 1'b0, 30);
    if (resp_log.size() == 2) check("tie2_order", {resp_log[0], resp_log[1]}, 128'b01);
    else check("tie2_count", 128'(resp_log.size()), 128'd2);

    // Single fetch read at 0x60, pmem answers in the first BUSY cycle, request held through resp
    pmem_lat = 1; pmem_base = 32'hDEAD_BEEF ^ 32'h60;
    ri = '{1'b1, 1'b0, 4'hF, 32'h60, 32'h0};
    resp_log.delete();
    rc = resp_cnt;
    run_req(1'b1, ri, 1'b0, idle_r, 1'b0, 20);
    check("fetch_rdata_lit", 128'(i_bus.rdata), 128'hDEAD_BEEF);
    check("fetch_only_i_resp", 128'(resp_log.size()), 128'd1);
    repeat (6) @(posedge clk);
    #1;
    check("held_no_second_txn", 128'(resp_cnt - rc), 128'd1);

    // Tie after a lone fetch grant: LSQ goes first
    pmem_lat = 3; pmem_base = 32'h2222_0000;
    resp_log.delete();
    run_req(1'b1, ri, 1'b1, rl, 1'b0, 30);
    if (resp_log.size() == 2) check("tie3_order", {resp_log[0], resp_log[1]}, 128'b10);
    else check("tie3_count", 128'(resp_log.size()), 128'd2);

    // LSQ write with inputs toggling during BUSY; write returns zero data
    pmem_lat = 3; pmem_base = 32'hFFFF_FFFF;
    rl = '{1'b0, 1'b1, 4'b0011, 32'h100, 32'h1234};
    run_req(1'b0, idle_r, 1'b1, rl, 1'b1, 20);
    check("lsq_write_rdata_lit", 128'(l_bus.rdata), 128'h0);

    // Read and write both high: serviced as a write
    pmem_lat = 2; pmem_base = 32'h3333_3333;
    ri = '{1'b1, 1'b1, 4'b1100, 32'h44, 32'hCAFE_0001};
    run_req(1'b1, ri, 1'b0, idle_r, 1'b0, 20);
    check("rw_as_write_rdata_lit", 128'(i_bus.rdata), 128'h0);

    // pmem_resp in the watchdog's last cycle is a real response
    pmem_lat = TMO; pmem_base = 32'h4444_0000;
    ri = '{1'b1, 1'b0, 4'hF, 32'h80, 32'h0};
    run_req(1'b1, ri, 1'b0, idle_r, 1'b0, 20);
    check("boundary_err_lit", 128'(err), 128'd0);
    check("boundary_rdata_lit", 128'(i_bus.rdata), 128'h4444_0080);

    // Stray pmem_resp while idle must be ignored
    rc = resp_cnt;
    inject_resp = 1'b1;
    repeat (2) @(posedge clk);
    #1 inject_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_pmem_resp", 128'(resp_cnt - rc), 128'd0);

    // Watchdog abort: no pmem response at all
    pmem_lat = 0;
    rl = '{1'b1, 1'b0, 4'hF, 32'h90, 32'h0};
    run_req(1'b0, idle_r, 1'b1, rl, 1'b0, 20);
    check("timeout_err_lit", 128'(err), 128'd1);
    check("timeout_rdata_lit", 128'(l_bus.rdata), 128'h0);

    // err is sticky across a good transaction
    pmem_lat = 1; pmem_base = 32'h5555_0000;
    ri = '{1'b1, 1'b0, 4'hF, 32'h64, 32'h0};
    run_req(1'b1, ri, 1'b0, idle_r, 1'b0, 20);
    check("err_sticky_lit", 128'(err), 128'd1);

    // Reset in the middle of BUSY, off the clock edge
    pmem_lat = 0;
    ri = '{1'b1, 1'b0, 4'hF, 32'h70, 32'h0};
    exp_q.push_back(predict(PORT_I, ri));
    drive_i(ri);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_busy", 128'(p_bus.read), 128'd1);
    #3 rst = 1'b0;
    #1;
    check("rst_mid_pmem_drop", {p_bus.read, p_bus.write, i_bus.resp, l_bus.resp}, 128'd0);
    check("rst_mid_clear", {err, i_bus.rdata, l_bus.rdata}, 128'd0);
    exp_q.delete();
    m_rdata_i = '0; m_rdata_l = '0; m_err = 1'b0; m_last = PORT_LSQ;
    drive_i(idle_r);
    rc = resp_cnt;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_no_resp", 128'(resp_cnt - rc), 128'd0);

    // After release: tie resolves to fetch first and both complete normally
    pmem_lat = 2; pmem_base = 32'h6666_0000;
    ri = '{1'b1, 1'b0, 4'hF, 32'h10, 32'h0};
    rl = '{1'b1, 1'b0, 4'hF, 32'h20, 32'h0};
    resp_log.delete();
    run_req(1'b1, ri, 1'b1, rl, 1'b0, 30);
    if (resp_log.size() == 2) check("post_rst_tie_order", {resp_log[0], resp_log[1]}, 128'b01);
    else check("post_rst_tie_count", 128'(resp_log.size()), 128'd2);
    check("post_rst_rdata_lit", {i_bus.rdata, l_bus.rdata}, {32'h6666_0010, 32'h6666_0020});

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    run_chk = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
